// File: rtl/gtfmac_vnc_freq_meas_ctrl.sv
// Periodic frequency-measurement sequencer: toggles one_second_edge for the clock counters,
// then scans per-channel counts against a [min,max] window. Optional lock tracking: GTFMAC_VNC_FREQ_LOCK_EN.
//
// state       | meaning
// IDLE        | measurement stopped, period counter cleared, edge held
// WAIT_EDGE   | waiting for the period counter to wrap (first wrap after IDLE discarded)
// SETTLE      | let the counters latch their new value after the edge toggle
// SCAN        | compare one channel per cycle into the shadow register
// REPORT      | publish the shadow results, pulse meas_valid, bump meas_count
module gtfmac_vnc_freq_meas_ctrl #(
    parameter int NUM_CH       = 4,
    parameter int PERIOD_TICKS = 100_000_000,
    parameter int SETTLE_TICKS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_CH*32-1:0] ch_count,
    input  logic [31:0]          limit_min,
    input  logic [31:0]          limit_max,
    input  logic                 err_clear,
    output logic                 one_second_edge,
    output logic                 meas_valid,
    output logic [NUM_CH-1:0]    ch_in_range,
    output logic [NUM_CH-1:0]    ch_err_sticky,
    output logic [15:0]          meas_count,
    output logic [NUM_CH-1:0]    ch_locked
);

    localparam int PW = $clog2(PERIOD_TICKS);
    localparam int SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_EDGE,
        S_SETTLE,
        S_SCAN,
        S_REPORT
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     period_cnt;
    logic [SW-1:0]     settle_cnt;
    logic [IW-1:0]     ch_idx;
    logic              warm_up;
    logic [NUM_CH-1:0] shadow;
    logic              wrap;
    logic [31:0]       cur_count;
    logic              cur_in_range;
    logic [NUM_CH-1:0] set_mask;

    assign wrap         = (state != S_IDLE) && (period_cnt == PW'(PERIOD_TICKS - 1));
    assign cur_count    = ch_count[32*ch_idx +: 32];
    // An inverted window (min > max) can never satisfy both bounds, so no special case is needed.
    assign cur_in_range = (limit_min <= cur_count) && (cur_count <= limit_max);

    always_comb begin
        set_mask = '0;
        if (state == S_SCAN && !cur_in_range)
            set_mask = NUM_CH'(1) << ch_idx;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (enable) state_nxt = S_WAIT_EDGE;
            S_WAIT_EDGE: begin
                if (!enable)
                    state_nxt = S_IDLE;
                else if (wrap && !warm_up)
                    state_nxt = S_SETTLE;
            end
            S_SETTLE:    if (settle_cnt == '0) state_nxt = S_SCAN;
            S_SCAN:      if (ch_idx == IW'(NUM_CH - 1)) state_nxt = S_REPORT;
            S_REPORT:    state_nxt = enable ? S_WAIT_EDGE : S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt      <= '0;
            one_second_edge <= 1'b0;
            warm_up         <= 1'b0;
            settle_cnt      <= '0;
            ch_idx          <= '0;
            shadow          <= '0;
            meas_valid      <= 1'b0;
            ch_in_range     <= '0;
            ch_err_sticky   <= '0;
            meas_count      <= '0;
        end else begin
            if (state == S_IDLE || wrap)
                period_cnt <= '0;
            else
                period_cnt <= period_cnt + 1'b1;

            if (wrap)
                one_second_edge <= ~one_second_edge;

            if (state == S_IDLE && enable)
                warm_up <= 1'b1;
            else if (state == S_WAIT_EDGE && wrap)
                warm_up <= 1'b0;

            if (state != S_SETTLE)
                settle_cnt <= SW'(SETTLE_TICKS - 1);
            else if (settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;

            if (state == S_SCAN)
                ch_idx <= ch_idx + 1'b1;
            else
                ch_idx <= '0;

            if (state == S_SCAN)
                shadow[ch_idx] <= cur_in_range;

            // A new out-of-range hit outranks a clear issued in the same cycle.
            ch_err_sticky <= (err_clear ? '0 : ch_err_sticky) | set_mask;

            meas_valid <= (state == S_REPORT);
            if (state == S_REPORT) begin
                ch_in_range <= shadow;
                if (meas_count != 16'hFFFF)
                    meas_count <= meas_count + 16'd1;
            end
        end
    end

`ifdef GTFMAC_VNC_FREQ_LOCK_EN
    logic [1:0] lock_cnt [NUM_CH];

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_locked <= '0;
            for (int i = 0; i < NUM_CH; i++)
                lock_cnt[i] <= 2'd0;
        end else if (state == S_REPORT) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!shadow[i])
                    lock_cnt[i] <= 2'd0;
                else if (lock_cnt[i] != 2'd3)
                    lock_cnt[i] <= lock_cnt[i] + 2'd1;
                // Registered alongside ch_in_range so lock is visible with meas_valid.
                ch_locked[i] <= shadow[i] && (lock_cnt[i] >= 2'd2);
            end
        end
    end
`else
    assign ch_locked = '0;
`endif

endmodule
